// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel synchronizer plus a four-state debounce FSM.
// Each channel reports its debounced level, rise/fall strobes and a
// long-press strobe. An optional prescaler strobe (tick_en) paces the
// bounce and hold counters, so debounce time is measured in ticks.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_0       | stable low
// S_MAYBE_1 | input went high, counting ticks before accepting it
// S_1       | stable high, hold counter running toward long_pulse
// S_MAYBE_0 | input went low, counting ticks; level_out is still 1
module multi_debouncer #(
    parameter int N_CH         = 4,
    parameter int BOUNCE_TICKS = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int LONG_TICKS   = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_en,
    input  logic [N_CH-1:0] bouncy_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic            any_change
);

    localparam int BW = $clog2(BOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_TICKS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);

    typedef enum logic [1:0] {
        S_0       = 2'd0,
        S_MAYBE_1 = 2'd1,
        S_1       = 2'd2,
        S_MAYBE_0 = 2'd3
    } state_t;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] commit_rise;
    logic [N_CH-1:0] commit_fall;

    // Synchronizer shift chain; only the last stage feeds the FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bouncy_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        state;
        logic [BW-1:0] bounce_cnt;
        logic [HW-1:0] hold_cnt;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;
        logic          long_q;

        // Commit conditions are shared with the any_change register so the
        // summary strobe lands in the same cycle as the per-channel strobes.
        assign commit_rise[i] = (state == S_MAYBE_1) && s[i] && tick_en &&
                                (bounce_cnt == B_LAST);
        assign commit_fall[i] = (state == S_MAYBE_0) && !s[i] && tick_en &&
                                (bounce_cnt == B_LAST);

        // Debounce FSM with registered level, edge strobes and long-press strobe.
        always_ff @(posedge clk) begin
            if (rst) begin
                state      <= S_0;
                bounce_cnt <= '0;
                hold_cnt   <= '0;
                level_q    <= 1'b0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                rise_q <= commit_rise[i];
                fall_q <= commit_fall[i];
                long_q <= 1'b0;
                case (state)
                    S_0: begin
                        if (s[i]) begin
                            state      <= S_MAYBE_1;
                            bounce_cnt <= '0;
                        end
                    end
                    S_MAYBE_1: begin
                        if (!s[i]) begin
                            state <= S_0;
                        end else if (tick_en) begin
                            if (bounce_cnt == B_LAST) begin
                                state    <= S_1;
                                level_q  <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                bounce_cnt <= bounce_cnt + 1'b1;
                            end
                        end
                    end
                    S_1: begin
                        // Hold counter saturates, so long_q can fire only once per press.
                        if (tick_en && (hold_cnt != H_MAX)) begin
                            hold_cnt <= hold_cnt + 1'b1;
                            long_q   <= (hold_cnt == H_LAST);
                        end
                        if (!s[i]) begin
                            state      <= S_MAYBE_0;
                            bounce_cnt <= '0;
                        end
                    end
                    S_MAYBE_0: begin
                        // A glitch returning here keeps hold_cnt, so no re-fire.
                        if (s[i]) begin
                            state <= S_1;
                        end else if (tick_en) begin
                            if (bounce_cnt == B_LAST) begin
                                state   <= S_0;
                                level_q <= 1'b0;
                            end else begin
                                bounce_cnt <= bounce_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= S_0;
                endcase
            end
        end

        assign level_out[i]  = level_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
        assign long_pulse[i] = long_q;
    end

    // Registered OR of all edge strobes across channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |(commit_rise | commit_fall);
        end
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: directed stimulus pushes expected
// strobe events (cycle, level, rise, fall, long) into a queue; a monitor pops
// and compares whenever the DUT shows any strobe.
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b0;
    logic [3:0] bouncy_in = 4'b0000;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] long_pulse;
    logic       any_change;

    multi_debouncer #(
        .N_CH(4), .BOUNCE_TICKS(4), .SYNC_STAGES(2), .LONG_TICKS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_en(tick_en),
        .bouncy_in(bouncy_in),
        .level_out(level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .long_pulse(long_pulse),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [3:0] lvl;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] l;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  errors = 0;
    int  checks = 0;
    bit  div2 = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            if (div2) tick_en = ~tick_en;
        end
    endtask

    task automatic expect_ev(int dc, logic [3:0] lvl, logic [3:0] r,
                             logic [3:0] f, logic [3:0] l);
        ev_t e;
        e.cyc = cyc + dc;
        e.lvl = lvl;
        e.r   = r;
        e.f   = f;
        e.l   = l;
        q.push_back(e);
    endtask

    // Monitor: any strobe from the DUT must match the next queued event.
    always @(negedge clk) begin
        if (!rst && (((rise_pulse | fall_pulse | long_pulse) != 4'b0) || any_change)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: cyc=%0d rise=%b fall=%b long=%b any=%b",
                         cyc, rise_pulse, fall_pulse, long_pulse, any_change);
            end else begin
                mon_e = q.pop_front();
                check("ev_cycle", cyc, mon_e.cyc);
                check("ev_level", {28'd0, level_out}, {28'd0, mon_e.lvl});
                check("ev_rise", {28'd0, rise_pulse}, {28'd0, mon_e.r});
                check("ev_fall", {28'd0, fall_pulse}, {28'd0, mon_e.f});
                check("ev_long", {28'd0, long_pulse}, {28'd0, mon_e.l});
                check("ev_any", {31'd0, any_change}, {31'd0, |(mon_e.r | mon_e.f)});
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_level", {28'd0, level_out}, 32'd0);
        check("rst_rise", {28'd0, rise_pulse}, 32'd0);
        check("rst_fall", {28'd0, fall_pulse}, 32'd0);
        check("rst_long", {28'd0, long_pulse}, 32'd0);
        check("rst_any", {31'd0, any_change}, 32'd0);
        rst = 1'b0;
        tick_en = 1'b1;
        step(2);

        // Scenario 1: clean rise on ch0, long press, release
        bouncy_in[0] = 1'b1;
        expect_ev(7, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        expect_ev(23, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        step(6);
        check("s1_level_before", {31'd0, level_out[0]}, 32'd0);
        step(1);
        check("s1_level_after", {31'd0, level_out[0]}, 32'd1);
        step(23);
        bouncy_in[0] = 1'b0;
        expect_ev(7, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step(12);

        // Scenario 2: ch1 toggles every 2 cycles, must never be accepted
        for (int i = 0; i < 40; i++) begin
            bouncy_in[1] = (((i / 2) % 2) == 0);
            step(1);
        end
        bouncy_in[1] = 1'b0;
        check("s2_level_mid", {31'd0, level_out[1]}, 32'd0);
        step(10);
        check("s2_level_end", {31'd0, level_out[1]}, 32'd0);

        // Scenario 3: ch2 held high, tick_en every 2nd cycle
        bouncy_in[2] = 1'b1;
        div2 = 1'b1;
        tick_en = 1'b0;
        expect_ev(10, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        expect_ev(42, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        step(82);
        div2 = 1'b0;
        tick_en = 1'b1;
        bouncy_in[2] = 1'b0;
        expect_ev(7, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        step(12);

        // Scenario 4: ch0 and ch3 together
        bouncy_in = 4'b1001;
        expect_ev(7, 4'b1001, 4'b1001, 4'b0000, 4'b0000);
        step(10);
        bouncy_in = 4'b0000;
        expect_ev(7, 4'b0000, 4'b0000, 4'b1001, 4'b0000);
        step(12);

        // Scenario 5: reset mid-hold on ch1 with input still high
        bouncy_in[1] = 1'b1;
        expect_ev(7, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        step(12);
        rst = 1'b1;
        step(1);
        check("s5_rst_level", {28'd0, level_out}, 32'd0);
        check("s5_rst_fall", {28'd0, fall_pulse}, 32'd0);
        step(2);
        check("s5_rst_any", {31'd0, any_change}, 32'd0);
        check("s5_rst_long", {28'd0, long_pulse}, 32'd0);
        rst = 1'b0;
        expect_ev(7, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        expect_ev(23, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        step(6);
        check("s5_level_before", {31'd0, level_out[1]}, 32'd0);
        step(24);
        bouncy_in[1] = 1'b0;
        expect_ev(7, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        step(12);

        // Scenario 6: 2-cycle low glitch on ch0 while in S_1
        bouncy_in[0] = 1'b1;
        expect_ev(7, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        expect_ev(25, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        expect_ev(37, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step(12);
        bouncy_in[0] = 1'b0;
        step(2);
        bouncy_in[0] = 1'b1;
        step(2);
        check("s6_level_glitch", {31'd0, level_out[0]}, 32'd1);
        step(14);
        bouncy_in[0] = 1'b0;
        step(12);

        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
